johnson_counter_param: RTL

//   Parametrised Johnson (twisted-ring) counter, successor to the fixed 4-bit counter.

---
 rtl/johnson_counter_param.sv | 80 ++++++++
 1 files changed

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, parallel load,
// illegal-load detection/correction, decoded state index and terminal-count strobe.
module johnson_counter_param #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1,
  parameter int IDX_W        = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] state_idx,
  output logic             tc,
  output logic             illegal
);

  localparam int               PERIOD   = 2*WIDTH;
  localparam logic [WIDTH-2:0] EDGE_ONE = (WIDTH-1)'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-2:0] trans_cur, trans_ld;
  logic             q_legal, ld_legal;
  logic [IDX_W-1:0] ones;
  logic [IDX_W-1:0] idx_raw;

  // A Johnson code has at most one position where neighbouring bits differ.
  assign trans_cur = q_q[WIDTH-2:0] ^ q_q[WIDTH-1:1];
  assign trans_ld  = load_val[WIDTH-2:0] ^ load_val[WIDTH-1:1];
  assign q_legal   = ((trans_cur & (trans_cur - EDGE_ONE)) == '0);
  assign ld_legal  = ((trans_ld & (trans_ld - EDGE_ONE)) == '0);

  always_comb begin
    q_d       = q_q;
    illegal_d = 1'b0;
    if (load) begin
      if (ld_legal) begin
        q_d = load_val;
      end else begin
        illegal_d = 1'b1;
        q_d       = SELF_CORRECT ? '0 : load_val;
      end
    end else if (en) begin
      q_d = dir ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]} : {~q_q[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IDX_W'(q_q[i]);
    end
  end

  // When PERIOD is a power of two IDX_W'(PERIOD) truncates to 0; modular subtraction still
  // yields PERIOD-ones because ones>=1 whenever the MSB is set.
  assign idx_raw   = q_q[WIDTH-1] ? (IDX_W'(PERIOD) - ones) : ones;
  assign state_idx = q_legal ? idx_raw : '0;

  assign tc = en & ~load & q_legal &
              ((dir & (state_idx == IDX_LAST)) | (~dir & (state_idx == '0)));

  assign q       = q_q;
  assign illegal = illegal_q;

endmodule
